// File: rtl/audio_sample_feeder_pkg.sv
// Shared definitions for the audio sample feeder: FSM encoding, I2S slot width
// and the bytes-per-sample helper.
package audio_sample_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH_L  = 2'd1,
    ST_FETCH_R  = 2'd2,
    ST_COMPLETE = 2'd3
  } feeder_state_t;

  localparam int SLOT_W = 32;

  function automatic int bytes_per_sample(input int sample_bits);
    return sample_bits / 8;
  endfunction

endpackage

// File: rtl/audio_byte_fetch.sv
// Single-outstanding byte FIFO read handshake: issues one read strobe at a time
// and flags the returned byte one cycle later.
module audio_byte_fetch (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic fifo_empty,
  output logic fifo_rd_en,
  output logic byte_valid
);

  logic in_flight;

  // A new read only goes out once the previous byte has come back.
  assign fifo_rd_en = req & ~fifo_empty & ~in_flight;
  assign byte_valid = in_flight;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_flight <= 1'b0;
    else     in_flight <= fifo_rd_en;
  end

endmodule

// File: rtl/audio_sample_feeder.sv
// Assembles little-endian PCM bytes into stereo frames, keeps one frame staged
// and presents it left-justified to the I2S transmitter on each read_data_en.
//
// state       | meaning
// ST_IDLE     | not playing, waiting for play_en
// ST_FETCH_L  | reading left-sample bytes, LSB first
// ST_FETCH_R  | reading right-sample bytes, LSB first
// ST_COMPLETE | working frame full, waiting for a free staging slot
module audio_sample_feeder
  import audio_sample_feeder_pkg::*;
#(
  parameter int SAMPLE_BITS = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             play_en,
  input  logic             mono,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [7:0]       fifo_rdata,
  input  logic             read_data_en,
  output logic [31:0]      left_data,
  output logic [31:0]      right_data,
  output logic             underrun,
  output logic [CNT_W-1:0] underrun_cnt
);

  localparam int         N_BYTES   = bytes_per_sample(SAMPLE_BITS);
  localparam logic [1:0] LAST_BYTE = 2'(N_BYTES - 1);

  feeder_state_t state, state_next;
  logic [1:0]    byte_cnt, byte_cnt_next;
  logic          mono_frame, mono_next;
  logic          fetch_req, byte_valid, capture, stage_load;

  logic [SAMPLE_BITS-1:0] work_l, work_r, stage_l, stage_r;
  logic                   stage_valid;

  assign fetch_req = play_en & ((state == ST_FETCH_L) | (state == ST_FETCH_R));
  // A byte returning after play_en drops belongs to a discarded frame.
  assign capture   = byte_valid & play_en;

  audio_byte_fetch u_fetch (
    .clk        (clk),
    .rst        (rst),
    .req        (fetch_req),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .byte_valid (byte_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      byte_cnt   <= 2'd0;
      mono_frame <= 1'b0;
    end else begin
      state      <= state_next;
      byte_cnt   <= byte_cnt_next;
      mono_frame <= mono_next;
    end
  end

  always_comb begin
    state_next    = state;
    byte_cnt_next = byte_cnt;
    mono_next     = mono_frame;
    stage_load    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (play_en) begin
          state_next = ST_FETCH_L;
          mono_next  = mono;
        end
      end
      ST_FETCH_L: begin
        if (capture) begin
          if (byte_cnt == LAST_BYTE) begin
            byte_cnt_next = 2'd0;
            state_next    = mono_frame ? ST_COMPLETE : ST_FETCH_R;
          end else begin
            byte_cnt_next = byte_cnt + 2'd1;
          end
        end
      end
      ST_FETCH_R: begin
        if (capture) begin
          if (byte_cnt == LAST_BYTE) begin
            byte_cnt_next = 2'd0;
            state_next    = ST_COMPLETE;
          end else begin
            byte_cnt_next = byte_cnt + 2'd1;
          end
        end
      end
      ST_COMPLETE: begin
        // Staging frees up either because it is empty or is being consumed now.
        if (!stage_valid || read_data_en) begin
          stage_load = 1'b1;
          state_next = ST_FETCH_L;
          mono_next  = mono;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (!play_en) begin
      state_next    = ST_IDLE;
      byte_cnt_next = 2'd0;
      stage_load    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_l       <= '0;
      work_r       <= '0;
      stage_l      <= '0;
      stage_r      <= '0;
      stage_valid  <= 1'b0;
      left_data    <= '0;
      right_data   <= '0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      underrun <= 1'b0;

      // Shift in from the top so byte0 ends up as the LSB after N bytes.
      if (capture && state == ST_FETCH_L)
        work_l <= {fifo_rdata, work_l[SAMPLE_BITS-1:8]};
      if (capture && state == ST_FETCH_R)
        work_r <= {fifo_rdata, work_r[SAMPLE_BITS-1:8]};

      if (read_data_en) begin
        if (stage_valid && play_en) begin
          left_data  <= {stage_l, {(SLOT_W-SAMPLE_BITS){1'b0}}};
          right_data <= {stage_r, {(SLOT_W-SAMPLE_BITS){1'b0}}};
        end else begin
          left_data  <= '0;
          right_data <= '0;
          if (play_en) begin
            underrun <= 1'b1;
            if (underrun_cnt != '1) underrun_cnt <= underrun_cnt + 1'b1;
          end
        end
      end

      if (!play_en) begin
        stage_valid <= 1'b0;
      end else if (stage_load) begin
        stage_valid <= 1'b1;
        stage_l     <= work_l;
        stage_r     <= mono_frame ? work_l : work_r;
      end else if (read_data_en) begin
        stage_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_audio_sample_feeder.sv
// Directed, table-driven bench for audio_sample_feeder with behavioural byte
// FIFOs; covers 16-bit (CNT_W=2) and 24-bit (CNT_W=16) instances.
module tb_audio_sample_feeder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 16-bit instance with a narrow counter
  logic        play16 = 1'b0, mono16 = 1'b0, rde16 = 1'b0;
  logic        rd16, e16, und16;
  logic [7:0]  rdata16;
  logic [31:0] left16, right16;
  logic [1:0]  cnt16;

  // 24-bit instance with the default counter width
  logic        play24 = 1'b0, mono24 = 1'b0, rde24 = 1'b0;
  logic        rd24, e24, und24;
  logic [7:0]  rdata24;
  logic [31:0] left24, right24;
  logic [15:0] cnt24;

  audio_sample_feeder #(.SAMPLE_BITS(16), .CNT_W(2)) u16 (
    .clk(clk), .rst(rst), .play_en(play16), .mono(mono16),
    .fifo_empty(e16), .fifo_rd_en(rd16), .fifo_rdata(rdata16),
    .read_data_en(rde16), .left_data(left16), .right_data(right16),
    .underrun(und16), .underrun_cnt(cnt16)
  );

  audio_sample_feeder #(.SAMPLE_BITS(24), .CNT_W(16)) u24 (
    .clk(clk), .rst(rst), .play_en(play24), .mono(mono24),
    .fifo_empty(e24), .fifo_rd_en(rd24), .fifo_rdata(rdata24),
    .read_data_en(rde24), .left_data(left24), .right_data(right24),
    .underrun(und24), .underrun_cnt(cnt24)
  );

  // Byte FIFO models: data appears the cycle after the read strobe.
  logic [7:0] mem16 [64];
  logic [7:0] mem24 [64];
  logic [5:0] wp16 = 6'd0, rp16 = 6'd0, wp24 = 6'd0, rp24 = 6'd0;
  assign e16 = (wp16 == rp16);
  assign e24 = (wp24 == rp24);

  int   rdcnt16 = 0, rdcnt24 = 0;
  logic prev16 = 1'b0, prev24 = 1'b0, consec16 = 1'b0, consec24 = 1'b0;

  always @(posedge clk) begin
    if (rd16) begin
      rdata16 <= mem16[rp16];
      rp16    <= rp16 + 6'd1;
      rdcnt16 <= rdcnt16 + 1;
    end
    if (rd24) begin
      rdata24 <= mem24[rp24];
      rp24    <= rp24 + 6'd1;
      rdcnt24 <= rdcnt24 + 1;
    end
    if (rd16 && prev16) consec16 <= 1'b1;
    if (rd24 && prev24) consec24 <= 1'b1;
    prev16 <= rd16;
    prev24 <= rd24;
  end

  task automatic push16(input logic [7:0] d);
    mem16[wp16] = d;
    wp16 = wp16 + 6'd1;
  endtask

  task automatic push24(input logic [7:0] d);
    mem24[wp24] = d;
    wp24 = wp24 + 6'd1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse16();
    rde16 = 1'b1;
    tick();
    rde16 = 1'b0;
  endtask

  task automatic pulse24();
    rde24 = 1'b1;
    tick();
    rde24 = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    play16 = 1'b0; play24 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    wp16 = rp16; wp24 = rp24;
    tick();
  endtask

  typedef struct {
    logic [31:0] bytes;
    int          n;
    logic        mono;
    logic [31:0] el;
    logic [31:0] er;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int base;
    logic [31:0] bb;

    vecs[0] = '{32'h5678_1234, 4, 1'b0, 32'h1234_0000, 32'h5678_0000};
    vecs[1] = '{32'h0000_ABCD, 2, 1'b1, 32'hABCD_0000, 32'hABCD_0000};
    vecs[2] = '{32'h0001_80FF, 4, 1'b0, 32'h80FF_0000, 32'h0001_0000};
    vecs[3] = '{32'hDDEE_7F00, 4, 1'b0, 32'h7F00_0000, 32'hDDEE_0000};

    // Reset values, observed while rst is held
    tick(); tick();
    chk("rst_left16",  left16,  32'h0);
    chk("rst_right16", right16, 32'h0);
    chk("rst_und16",   {31'h0, und16}, 32'h0);
    chk("rst_cnt16",   {30'h0, cnt16}, 32'h0);
    chk("rst_rd16",    {31'h0, rd16},  32'h0);
    chk("rst_left24",  left24,  32'h0);
    chk("rst_cnt24",   {16'h0, cnt24}, 32'h0);
    do_reset();

    // Table-driven single frames on the 16-bit instance
    for (int i = 0; i < 4; i++) begin
      play16 = 1'b0;
      tick(); tick();
      wp16 = rp16;
      mono16 = vecs[i].mono;
      bb = vecs[i].bytes;
      for (int k = 0; k < vecs[i].n; k++) push16(bb[8*k +: 8]);
      base = rdcnt16;
      play16 = 1'b1;
      repeat (20) tick();
      pulse16();
      chk($sformatf("vec%0d_left", i),  left16,  vecs[i].el);
      chk($sformatf("vec%0d_right", i), right16, vecs[i].er);
      chk($sformatf("vec%0d_und", i),   {31'h0, und16}, 32'h0);
      chk($sformatf("vec%0d_rdcnt", i), rdcnt16 - base, vecs[i].n);
    end
    mono16 = 1'b0;

    // Staging full and working frame complete: fetch stalls until consumed
    do_reset();
    foreach (vecs[0].bytes[j]) ;
    push16(8'h11); push16(8'h22); push16(8'h33); push16(8'h44);
    push16(8'h55); push16(8'h66); push16(8'h77); push16(8'h88);
    push16(8'h99); push16(8'hAA);
    base = rdcnt16;
    play16 = 1'b1;
    repeat (40) tick();
    chk("hold_rdcnt", rdcnt16 - base, 8);
    chk("hold_rd_now", {31'h0, rd16}, 32'h0);
    pulse16();
    chk("hold_left1",  left16,  32'h2211_0000);
    chk("hold_right1", right16, 32'h4433_0000);
    chk("hold_fetch_restart", {31'h0, rd16}, 32'h1);
    pulse16();
    chk("hold_left2",  left16,  32'h6655_0000);
    chk("hold_right2", right16, 32'h8877_0000);
    chk("hold_und",    {31'h0, und16}, 32'h0);

    // play_en dropped in FETCH_R with a read in flight
    do_reset();
    push16(8'h01); push16(8'h02); push16(8'h03); push16(8'h04);
    push16(8'h05); push16(8'h06); push16(8'h07);
    base = rdcnt16;
    play16 = 1'b1;
    for (int t = 0; t < 60; t++) begin
      tick();
      if (rdcnt16 - base == 7) break;
    end
    chk("drop_wait_rd7", rdcnt16 - base, 7);
    play16 = 1'b0;
    repeat (5) tick();
    chk("drop_no_rd", rdcnt16 - base, 7);
    pulse16();
    chk("drop_left",  left16,  32'h0);
    chk("drop_right", right16, 32'h0);
    chk("drop_und",   {31'h0, und16}, 32'h0);
    chk("drop_cnt",   {30'h0, cnt16}, 32'h0);
    wp16 = rp16;
    push16(8'hA1); push16(8'hB2); push16(8'hC3); push16(8'hD4);
    play16 = 1'b1;
    repeat (20) tick();
    pulse16();
    chk("reen_left",  left16,  32'hB2A1_0000);
    chk("reen_right", right16, 32'hD4C3_0000);

    // Underruns with an empty FIFO; 2-bit counter saturates at 3
    do_reset();
    play16 = 1'b1;
    repeat (4) tick();
    for (int p = 0; p < 5; p++) begin
      pulse16();
      chk($sformatf("ur%0d_pulse", p), {31'h0, und16}, 32'h1);
      chk($sformatf("ur%0d_cnt", p), {30'h0, cnt16}, (p < 3) ? p + 1 : 3);
      tick();
      chk($sformatf("ur%0d_oneshot", p), {31'h0, und16}, 32'h0);
    end
    chk("ur_left",  left16,  32'h0);
    chk("ur_right", right16, 32'h0);
    play16 = 1'b0;

    // 24-bit stereo frame, then underruns on the 16-bit wide counter
    push24(8'h01); push24(8'h02); push24(8'h03);
    push24(8'h04); push24(8'h05); push24(8'h06);
    base = rdcnt24;
    play24 = 1'b1;
    repeat (30) tick();
    chk("s24_rdcnt", rdcnt24 - base, 6);
    pulse24();
    chk("s24_left",  left24,  32'h0302_0100);
    chk("s24_right", right24, 32'h0605_0400);
    chk("s24_und",   {31'h0, und24}, 32'h0);
    chk("s24_consec", {31'h0, consec24}, 32'h0);
    for (int p = 0; p < 3; p++) begin
      tick();
      pulse24();
      chk($sformatf("s24_ur%0d", p), {31'h0, und24}, 32'h1);
    end
    chk("s24_ur_cnt",  {16'h0, cnt24}, 32'd3);
    chk("s24_ur_left", left24, 32'h0);
    chk("s24_ur_right", right24, 32'h0);
    chk("s16_consec", {31'h0, consec16}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
